// File: rtl/bsg_mul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing controller.
package bsg_mul_share_pkg;

    localparam int perf_cnt_width_lp = 32;

    typedef enum logic {
        eRUN   = 1'b0,
        eDRAIN = 1'b1
    } state_e;

    function automatic int tag_width(input int num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/bsg_mul_share_if.sv
// Request, multiplier and result bus of the sharing controller; slave = controller side.
interface bsg_mul_share_if #(
    parameter int width_p   = 64,
    parameter int num_req_p = 4
);
    import bsg_mul_share_pkg::*;

    localparam int tag_w_lp = tag_width(num_req_p);

    logic [num_req_p-1:0]         v_i;
    logic [num_req_p*width_p-1:0] x_i;
    logic [num_req_p*width_p-1:0] y_i;
    logic [num_req_p-1:0]         signed_i;
    logic [num_req_p-1:0]         ready_o;

    logic [width_p-1:0]           mul_x_o;
    logic [width_p-1:0]           mul_y_o;
    logic                         mul_signed_o;
    logic                         mul_en_o;
    logic [2*width_p-1:0]         mul_z_i;

    logic                         v_o;
    logic [2*width_p-1:0]         z_o;
    logic [tag_w_lp-1:0]          id_o;
    logic                         yumi_i;

    logic                         flush_i;
    logic                         flush_done_o;

    modport slave (
        input  v_i, x_i, y_i, signed_i, mul_z_i, yumi_i, flush_i,
        output ready_o, mul_x_o, mul_y_o, mul_signed_o, mul_en_o,
               v_o, z_o, id_o, flush_done_o
    );

    modport master (
        output v_i, x_i, y_i, signed_i, mul_z_i, yumi_i, flush_i,
        input  ready_o, mul_x_o, mul_y_o, mul_signed_o, mul_en_o,
               v_o, z_o, id_o, flush_done_o
    );

endinterface

// File: rtl/bsg_mul_share_rr_arb.sv
// Round-robin arbiter: first valid requester at/after the pointer wins; pointer moves past the winner.
module bsg_mul_share_rr_arb #(
    parameter int num_req_p = 4,
    parameter int tag_w_p   = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [num_req_p-1:0] v_i,
    input  logic                 en_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [tag_w_p-1:0]   id_o,
    output logic                 v_o
);

    logic [tag_w_p-1:0] ptr_r;
    int                 idx;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        v_o     = 1'b0;
        idx     = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = (int'(ptr_r) + i) % num_req_p;
            if (en_i && !v_o && v_i[idx]) begin
                v_o          = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = tag_w_p'(idx);
            end
        end
    end

    // With a single requester the wrap compare is always true, so the pointer stays at 0.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= '0;
        end else if (v_o) begin
            ptr_r <= (id_o == tag_w_p'(num_req_p - 1)) ? '0 : id_o + 1'b1;
        end
    end

endmodule

// File: rtl/bsg_mul_share_ctrl.sv
// Shares one fixed-latency pipelined multiplier among num_req_p requesters with drain/flush.
// Optional perf counters (issue_cnt_o, stall_cnt_o) under BSG_MUL_SHARE_PERF_EN.
//
// state  | meaning
// eRUN   | normal issue, round-robin grants while the pipe advances
// eDRAIN | no issue; wait for tag pipe empty and result taken, then pulse flush_done_o
module bsg_mul_share_ctrl
    import bsg_mul_share_pkg::*;
#(
    parameter int width_p       = 64,
    parameter int num_req_p     = 4,
    parameter int mul_latency_p = 4
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    bsg_mul_share_if.slave bus
`ifdef BSG_MUL_SHARE_PERF_EN
    ,
    output logic [perf_cnt_width_lp-1:0] issue_cnt_o,
    output logic [perf_cnt_width_lp-1:0] stall_cnt_o
`endif
);

    localparam int tag_w_lp = tag_width(num_req_p);

    state_e                 state_r, state_n;
    logic                   flush_done;
    logic                   mul_en;
    logic                   issue_en;
    logic [num_req_p-1:0]   grant;
    logic [tag_w_lp-1:0]    gnt_id;
    logic                   gnt_v;

    logic [width_p-1:0]     x_hold_r, y_hold_r;
    logic                   s_hold_r;

    logic [mul_latency_p-1:0] tag_v_r;
    logic [tag_w_lp-1:0]      tag_id_r [mul_latency_p];
    logic                     tail_v;
    logic [tag_w_lp-1:0]      tail_id;

    logic                   v_r;
    logic [2*width_p-1:0]   z_r;
    logic [tag_w_lp-1:0]    id_r;

    // Reset gates the enable directly so the multiplier sees no advance while reset is held.
    assign mul_en   = reset_n_i & ~(v_r & ~bus.yumi_i);
    assign issue_en = mul_en & (state_r == eRUN);

    bsg_mul_share_rr_arb #(
        .num_req_p (num_req_p),
        .tag_w_p   (tag_w_lp)
    ) u_arb (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .v_i       (bus.v_i),
        .en_i      (issue_en),
        .grant_o   (grant),
        .id_o      (gnt_id),
        .v_o       (gnt_v)
    );

    always_comb begin
        bus.mul_x_o      = x_hold_r;
        bus.mul_y_o      = y_hold_r;
        bus.mul_signed_o = s_hold_r;
        if (gnt_v) begin
            bus.mul_x_o      = bus.x_i[int'(gnt_id)*width_p +: width_p];
            bus.mul_y_o      = bus.y_i[int'(gnt_id)*width_p +: width_p];
            bus.mul_signed_o = bus.signed_i[gnt_id];
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            x_hold_r <= '0;
            y_hold_r <= '0;
            s_hold_r <= 1'b0;
        end else if (gnt_v) begin
            x_hold_r <= bus.mul_x_o;
            y_hold_r <= bus.mul_y_o;
            s_hold_r <= bus.mul_signed_o;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tag_v_r <= '0;
            for (int k = 0; k < mul_latency_p; k++) begin
                tag_id_r[k] <= '0;
            end
        end else if (mul_en) begin
            tag_v_r[0]  <= gnt_v;
            tag_id_r[0] <= gnt_id;
            for (int k = 1; k < mul_latency_p; k++) begin
                tag_v_r[k]  <= tag_v_r[k-1];
                tag_id_r[k] <= tag_id_r[k-1];
            end
        end
    end

    assign tail_v  = tag_v_r[mul_latency_p-1];
    assign tail_id = tag_id_r[mul_latency_p-1];

    // A load in the same cycle as yumi replaces the old result, keeping one result per cycle.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_r  <= 1'b0;
            z_r  <= '0;
            id_r <= '0;
        end else if (tail_v && mul_en) begin
            v_r  <= 1'b1;
            z_r  <= bus.mul_z_i;
            id_r <= tail_id;
        end else if (bus.yumi_i) begin
            v_r  <= 1'b0;
        end
    end

    always_comb begin
        state_n    = state_r;
        flush_done = 1'b0;
        case (state_r)
            eRUN: begin
                if (bus.flush_i) state_n = eDRAIN;
            end
            eDRAIN: begin
                if (!(|tag_v_r) && !v_r) begin
                    state_n    = eRUN;
                    flush_done = 1'b1;
                end
            end
            default: state_n = eRUN;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= eRUN;
        else            state_r <= state_n;
    end

    assign bus.ready_o      = grant;
    assign bus.mul_en_o     = mul_en;
    assign bus.v_o          = v_r;
    assign bus.z_o          = z_r;
    assign bus.id_o         = id_r;
    assign bus.flush_done_o = flush_done;

`ifdef BSG_MUL_SHARE_PERF_EN
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            issue_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else if (flush_done) begin
            issue_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (gnt_v)                   issue_cnt_o <= issue_cnt_o + 1'b1;
            if (!mul_en && (|bus.v_i))   stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mul_share_ctrl.sv
// Scoreboard bench for bsg_mul_share_ctrl with a behavioural 4-stage multiplier.
module tb_bsg_mul_share_ctrl;

    localparam int W = 64;
    localparam int N = 4;
    localparam int L = 4;

    typedef struct {
        logic [1:0]   id;
        logic [127:0] z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    bsg_mul_share_if #(.width_p(W), .num_req_p(N)) bus ();

`ifdef BSG_MUL_SHARE_PERF_EN
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;
`endif

    bsg_mul_share_ctrl #(
        .width_p       (W),
        .num_req_p     (N),
        .mul_latency_p (L)
    ) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
`ifdef BSG_MUL_SHARE_PERF_EN
        ,
        .issue_cnt_o (issue_cnt),
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mul_model(input logic [63:0] x, input logic [63:0] y,
                                               input logic s);
        logic [127:0] xe, ye;
        xe = s ? {{64{x[63]}}, x} : {64'b0, x};
        ye = s ? {{64{y[63]}}, y} : {64'b0, y};
        return xe * ye;
    endfunction

    logic [127:0] mpipe [L];
    always @(posedge clk) begin
        if (bus.mul_en_o) begin
            mpipe[0] <= mul_model(bus.mul_x_o, bus.mul_y_o, bus.mul_signed_o);
            for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign bus.mul_z_i = mpipe[L-1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [127:0] z);
        exp_t e;
        e.id = id;
        e.z  = z;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int r, input logic [63:0] x, input logic [63:0] y, input logic s);
        bus.x_i[r*W +: W] = x;
        bus.y_i[r*W +: W] = y;
        bus.signed_i[r]   = s;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.v_i     = '0;
        bus.flush_i = 1'b0;
        bus.yumi_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(exp_q.size()), 128'd0);
    endtask

    // Monitor: every result taken by the consumer must match the head of the queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.v_o && bus.yumi_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result id=%0d z=%0h required=none", bus.id_o, bus.z_o);
                end else begin
                    e = exp_q.pop_front();
                    check("result_id", 128'(bus.id_o), 128'(e.id));
                    check("result_z", bus.z_o, e.z);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int           cyc;
        int           cnt;
        int           done_cnt;
        logic [3:0]   exp_rdy;

        rst_n        = 1'b0;
        bus.v_i      = '0;
        bus.x_i      = '0;
        bus.y_i      = '0;
        bus.signed_i = '0;
        bus.yumi_i   = 1'b0;
        bus.flush_i  = 1'b0;

        // reset values while reset is held
        #3;
        check("rst_ready", 128'(bus.ready_o), 128'd0);
        check("rst_v_o", 128'(bus.v_o), 128'd0);
        check("rst_z_o", bus.z_o, 128'd0);
        check("rst_id_o", 128'(bus.id_o), 128'd0);
        check("rst_mul_en", 128'(bus.mul_en_o), 128'd0);
        check("rst_flush_done", 128'(bus.flush_done_o), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_mul_en", 128'(bus.mul_en_o), 128'd1);

        // single requester 1: 3*5, latency check
        @(posedge clk); #1;
        set_req(1, 64'd3, 64'd5, 1'b0);
        bus.v_i    = 4'b0010;
        bus.yumi_i = 1'b1;
        push_exp(2'd1, 128'd15);
        @(negedge clk);
        check("single_ready", 128'(bus.ready_o), 128'b0010);
        @(posedge clk); #1 bus.v_i = '0;
        cyc = 1;
        while (cyc < 20) begin
            @(negedge clk);
            if (bus.v_o) break;
            cyc++;
        end
        check("single_latency", 128'(cyc), 128'(L + 1));
        wait_drain("single_drain");

        // all four requesting: grants 0,1,2,3,0,1,2,3 from a fresh pointer
        do_reset();
        @(posedge clk); #1;
        for (int r = 0; r < N; r++) set_req(r, 64'(r + 1), 64'd10, 1'b0);
        bus.yumi_i = 1'b1;
        bus.v_i    = 4'b1111;
        for (int k = 0; k < 8; k++) push_exp(2'(k % 4), 128'(10 * ((k % 4) + 1)));
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_rdy = 4'b0001 << (k % 4);
            check("rr_ready", 128'(bus.ready_o), 128'(exp_rdy));
            if (bus.v_o) cnt++;
        end
        @(posedge clk); #1 bus.v_i = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.v_o) cnt++;
        end
        check("rr_result_cycles", 128'(cnt), 128'd8);
        wait_drain("rr_drain");

        // signed then unsigned (2^64-2)*3 on requester 2
        @(posedge clk); #1;
        set_req(2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1);
        bus.v_i = 4'b0100;
        push_exp(2'd2, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);
        @(negedge clk);
        check("signed_mode_out", 128'(bus.mul_signed_o), 128'd1);
        @(posedge clk); #1;
        bus.signed_i[2] = 1'b0;
        push_exp(2'd2, 128'h0000_0000_0000_0002_FFFF_FFFF_FFFF_FFFA);
        @(posedge clk); #1 bus.v_i = '0;
        wait_drain("signed_drain");

        // back-pressure: consumer stalls, five issued before the first result blocks the pipe
        do_reset();
        @(posedge clk); #1;
        set_req(0, 64'd7, 64'd6, 1'b0);
        set_req(3, 64'd9, 64'd9, 1'b0);
        bus.yumi_i = 1'b0;
        bus.v_i    = 4'b1001;
        push_exp(2'd0, 128'd42);
        push_exp(2'd3, 128'd81);
        push_exp(2'd0, 128'd42);
        push_exp(2'd3, 128'd81);
        push_exp(2'd0, 128'd42);
        cyc = 0;
        while (!bus.v_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("stall_v_seen", 128'(bus.v_o), 128'd1);
        for (int i = 0; i < 10; i++) begin
            check("stall_mul_en", 128'(bus.mul_en_o), 128'd0);
            check("stall_ready", 128'(bus.ready_o), 128'd0);
            @(negedge clk);
        end
        check("stall_hold_z", bus.z_o, 128'd42);
        @(posedge clk); #1;
        bus.v_i    = '0;
        bus.yumi_i = 1'b1;
        wait_drain("stall_drain");

        // flush with three in flight
        do_reset();
        @(posedge clk); #1;
        for (int r = 0; r < N; r++) set_req(r, 64'(r + 1), 64'd10, 1'b0);
        bus.yumi_i = 1'b1;
        bus.v_i    = 4'b0111;
        push_exp(2'd0, 128'd10);
        push_exp(2'd1, 128'd20);
        push_exp(2'd2, 128'd30);
        repeat (3) @(posedge clk);
        #1;
        bus.v_i     = '0;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.v_i     = 4'b1111;
        done_cnt = 0;
        cyc = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            check("drain_ready", 128'(bus.ready_o), 128'd0);
            if (bus.flush_done_o) begin
                done_cnt++;
                break;
            end
        end
        check("flush_queue_empty", 128'(exp_q.size()), 128'd0);
        @(posedge clk); #1 bus.v_i = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.flush_done_o) done_cnt++;
        end
        check("flush_done_pulses", 128'(done_cnt), 128'd1);
`ifdef BSG_MUL_SHARE_PERF_EN
        check("perf_issue_cleared", 128'(issue_cnt), 128'd0);
`endif

        // reset with two in flight
        @(posedge clk); #1;
        bus.v_i = 4'b0011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.v_i = '0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_v_o", 128'(bus.v_o), 128'd0);
        check("midrst_z_o", bus.z_o, 128'd0);
        check("midrst_id_o", 128'(bus.id_o), 128'd0);
        check("midrst_ready", 128'(bus.ready_o), 128'd0);
        check("midrst_mul_en", 128'(bus.mul_en_o), 128'd0);
        check("midrst_mul_x", 128'(bus.mul_x_o), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.v_o) cnt++;
        end
        check("no_stale_v_o", 128'(cnt), 128'd0);

        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
